// File: rtl/mux_event_logger.sv
// Change-event logger for the partial_case_assign mux: synchronises x/y, queues a
// {sel,x,y} snapshot on every change of the pair and keeps rise/drop statistics.
module mux_event_logger #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic             x,
    input  logic             y,
    input  logic             clr,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [3:0]       ev_data,
    output logic [CNT_W-1:0] x_rise_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic          x_s1, x_s2, y_s1, y_s2;
    logic          x_p, y_p;
    logic [1:0]    sel_d1, sel_d2;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    mem [DEPTH];

    logic full, empty, change, pop, push, drop, x_rise;

    // sel travels through the same two-stage delay as x/y so the payload stays aligned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_s1   <= 1'b0;
            x_s2   <= 1'b0;
            y_s1   <= 1'b0;
            y_s2   <= 1'b0;
            x_p    <= 1'b0;
            y_p    <= 1'b0;
            sel_d1 <= 2'b00;
            sel_d2 <= 2'b00;
        end else begin
            x_s1   <= x;
            x_s2   <= x_s1;
            y_s1   <= y;
            y_s2   <= y_s1;
            x_p    <= x_s2;
            y_p    <= y_s2;
            sel_d1 <= sel;
            sel_d2 <= sel_d1;
        end
    end

    assign change = {x_s2, y_s2} != {x_p, y_p};
    assign x_rise = x_s2 && !x_p;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ev_valid = !empty;
    assign pop      = ev_valid && ev_ready;
    assign push     = change && (!full || pop);
    assign drop     = change && full && !pop;
    assign ev_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // When full with a pop, the write slot equals the read slot; the old head is
    // read combinationally before this edge overwrites it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {sel_d2, x_s2, y_s2};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_rise_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else if (clr) begin
            x_rise_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (x_rise && (x_rise_cnt != '1)) x_rise_cnt <= x_rise_cnt + CNT_W'(1);
            if (drop && (drop_cnt != '1))     drop_cnt   <= drop_cnt + CNT_W'(1);
            if (drop)                         overflow   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_event_logger.sv
// Directed bench for mux_event_logger: expected snapshots are queued as stimulus is
// driven and compared whenever the DUT hands an entry over the valid/ready port.
module tb_mux_event_logger;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic       x, y, clr;
    logic       ev_valid, ev_ready;
    logic [3:0] ev_data;
    logic [7:0] x_rise_cnt, drop_cnt;
    logic       overflow;

    int         checks   = 0;
    int         errors   = 0;
    int         popCount = 0;
    int         expRise  = 0;
    int         pc0;
    logic [3:0] expQ [$];
    logic [3:0] expHead;

    mux_event_logger #(.DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .x          (x),
        .y          (y),
        .clr        (clr),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_data    (ev_data),
        .x_rise_cnt (x_rise_cnt),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] s, input logic xv, input logic yv, input bit stored);
        sel = s;
        x   = xv;
        y   = yv;
        if (stored) expQ.push_back({s, xv, yv});
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || ev_valid) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_left", 32'(expQ.size()) + 32'(ev_valid), 32'd0);
    endtask

    // Scoreboard: every accepted head entry must match the oldest expected snapshot
    always @(negedge clk) begin
        if (reset && ev_valid && ev_ready) begin
            popCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pop", 32'(ev_valid), 32'd0);
            end else begin
                expHead = expQ.pop_front();
                checkOutput("pop_data", 32'(ev_data), 32'(expHead));
            end
        end
    end

    initial begin
        reset    = 1'b0;
        clr      = 1'b0;
        ev_ready = 1'b0;
        sel      = 2'b01;
        x        = 1'b1;
        y        = 1'b1;
        repeat (3) tick();
        checkOutput("rst_valid", 32'(ev_valid), 32'd0);
        checkOutput("rst_rise", 32'(x_rise_cnt), 32'd0);
        checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);

        // inputs already high at release become an event three edges later
        reset = 1'b1;
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b1);
        expRise = 1;
        tick();
        tick();
        checkOutput("rst_e1_valid", 32'(ev_valid), 32'd0);
        tick();
        checkOutput("rst_e2_valid", 32'(ev_valid), 32'd1);
        checkOutput("rst_e2_data", 32'(ev_data), 32'(expQ[0]));
        checkOutput("rst_e2_rise", 32'(x_rise_cnt), 32'(expRise));

        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
        ev_ready = 1'b1;
        waitDrain(20);
        ev_ready = 1'b0;

        // latency and payload with y rising under sel=10
        applyStimulus(2'b10, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("lat_e1_valid", 32'(ev_valid), 32'd0);
        tick();
        checkOutput("lat_e2_valid", 32'(ev_valid), 32'd1);
        checkOutput("lat_e2_data", 32'(ev_data), 32'h9);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_data", 32'(ev_data), 32'h9);
        end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checkOutput("pop_valid_drop", 32'(ev_valid), 32'd0);

        // x and y change in the same cycle: a single entry
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
        expRise++;
        repeat (4) tick();
        checkOutput("simul_valid", 32'(ev_valid), 32'd1);
        checkOutput("simul_rise", 32'(x_rise_cnt), 32'(expRise));
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checkOutput("simul_one_entry", 32'(ev_valid), 32'd0);

        // six back-to-back events into a 4-deep FIFO: last two are dropped
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'(i), x, ~y, i < 4);
            tick();
        end
        repeat (3) tick();
        checkOutput("fill_drop", 32'(drop_cnt), 32'd2);
        checkOutput("fill_ovf", 32'(overflow), 32'd1);
        checkOutput("fill_valid", 32'(ev_valid), 32'd1);
        ev_ready = 1'b1;
        waitDrain(20);
        ev_ready = 1'b0;

        // full FIFO, event arrives on the same edge as a pop
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b01, x, ~y, 1'b1);
            tick();
        end
        repeat (3) tick();
        checkOutput("full_pre_drop", 32'(drop_cnt), 32'd2);
        applyStimulus(2'b10, x, ~y, 1'b1);
        tick();
        tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checkOutput("full_pushpop_drop", 32'(drop_cnt), 32'd2);
        checkOutput("full_pushpop_valid", 32'(ev_valid), 32'd1);
        checkOutput("full_ovf_sticky", 32'(overflow), 32'd1);
        pc0 = popCount;
        ev_ready = 1'b1;
        waitDrain(20);
        checkOutput("full_pushpop_occupancy", 32'(popCount - pc0), 32'd4);

        // drive x_rise_cnt to saturation with ev_ready held high
        applyStimulus(2'b00, 1'b0, y, 1'b1);
        tick();
        while (expRise < 255) begin
            applyStimulus(2'b01, 1'b1, y, 1'b1);
            expRise++;
            tick();
            applyStimulus(2'b01, 1'b0, y, 1'b1);
            tick();
        end
        repeat (3) tick();
        checkOutput("rise_at_max", 32'(x_rise_cnt), 32'd255);
        applyStimulus(2'b10, 1'b1, y, 1'b1);
        tick();
        applyStimulus(2'b10, 1'b0, y, 1'b1);
        tick();
        repeat (3) tick();
        checkOutput("rise_sat", 32'(x_rise_cnt), 32'd255);
        waitDrain(20);
        ev_ready = 1'b0;

        // clr on the same edge as a rise wins, FIFO keeps its entry
        applyStimulus(2'b11, 1'b1, y, 1'b1);
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr_rise", 32'(x_rise_cnt), 32'd0);
        checkOutput("clr_drop", 32'(drop_cnt), 32'd0);
        checkOutput("clr_ovf", 32'(overflow), 32'd0);
        checkOutput("clr_fifo_valid", 32'(ev_valid), 32'd1);
        checkOutput("clr_fifo_data", 32'(ev_data), 32'(expQ[0]));
        applyStimulus(2'b00, 1'b0, y, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b1, y, 1'b1);
        tick();
        repeat (3) tick();
        checkOutput("rise_after_clr", 32'(x_rise_cnt), 32'd1);
        ev_ready = 1'b1;
        waitDrain(20);
        ev_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
